// File: rtl/sort_pkg.sv
// Shared definitions for the selection-sort engine: memory geometry and session states.
package sort_pkg;

    localparam int unsigned SORT_DEPTH = 8;
    localparam int unsigned SORT_AW    = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClr,
        StStart,
        StSort,
        StDrain,
        StErr
    } sess_state_t;

endpackage

// File: rtl/sort_watchdog.sv
// Cycle counter bounding the time spent waiting on the sort controller.
module sort_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the last permitted cycle so the owner leaves exactly TIMEOUT cycles after entry.
    assign o_expire = i_en && (r_cnt == CntLast);

endmodule

// File: rtl/sort_session_ctrl.sv
// Session sequencer: loads 8 words into sort memory, runs the sorter, streams the result out.
module sort_session_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_abort,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [DW-1:0]      i_in_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DW-1:0]      o_out_data,
    output logic               o_out_last,
    output logic [SORT_AW-1:0] o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
    output logic               o_mem_we,
    input  logic [DW-1:0]      i_mem_rdata,
    output logic               o_mem_owner,
    output logic               o_sort_clr,
    output logic               o_sort_start,
    input  logic               i_sort_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam logic [SORT_AW-1:0] PtrLast = SORT_AW'(SORT_DEPTH - 1);

    sess_state_t        r_state, w_state_d;
    logic [SORT_AW-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [SORT_AW-1:0] r_rd_ptr, w_rd_ptr_d;
    logic               w_abort, w_in_ready, w_in_hs, w_out_valid, w_out_hs;
    logic               w_wd_clr, w_wd_en, w_expire;

    // Abort in IDLE only blocks the load handshake; everywhere else it tears the session down.
    assign w_abort     = i_abort && (r_state != StIdle);
    assign w_in_ready  = i_reset && !i_abort && ((r_state == StIdle) || (r_state == StLoad));
    assign w_in_hs     = w_in_ready && i_in_valid;
    assign w_out_valid = (r_state == StDrain) && !i_abort;
    assign w_out_hs    = w_out_valid && i_out_ready;
    assign w_wd_clr    = (r_state == StStart) || w_abort;
    assign w_wd_en     = (r_state == StSort);

    sort_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_reset),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        if (w_abort) begin
            w_state_d  = StIdle;
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_in_hs) begin
                        w_state_d  = StLoad;
                        w_wr_ptr_d = r_wr_ptr + 1'b1;
                    end
                end
                StLoad: begin
                    if (w_in_hs) begin
                        if (r_wr_ptr == PtrLast) begin
                            w_state_d = StClr;
                        end else begin
                            w_wr_ptr_d = r_wr_ptr + 1'b1;
                        end
                    end
                end
                StClr:   w_state_d = StStart;
                StStart: w_state_d = StSort;
                StSort: begin
                    if (i_sort_done) begin
                        w_state_d  = StDrain;
                        w_rd_ptr_d = '0;
                    end else if (w_expire) begin
                        w_state_d = StErr;
                    end
                end
                StDrain: begin
                    if (w_out_hs) begin
                        w_rd_ptr_d = r_rd_ptr + 1'b1;
                        if (r_rd_ptr == PtrLast) begin
                            w_state_d  = StIdle;
                            w_wr_ptr_d = '0;
                        end
                    end
                end
                StErr:   w_state_d = StErr;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        o_in_ready   = w_in_ready;
        o_mem_we     = w_in_hs;
        o_mem_wdata  = w_in_hs ? i_in_data : '0;
        o_mem_addr   = '0;
        o_mem_owner  = (r_state == StClr) || (r_state == StStart) || (r_state == StSort);
        o_sort_clr   = (r_state == StClr) || w_abort;
        o_sort_start = (r_state == StStart) && !i_abort;
        o_out_valid  = w_out_valid;
        o_out_data   = (r_state == StDrain) ? i_mem_rdata : '0;
        o_out_last   = w_out_valid && (r_rd_ptr == PtrLast);
        o_busy       = (r_state != StIdle);
        o_err        = (r_state == StErr);
        if ((r_state == StIdle) || (r_state == StLoad)) begin
            o_mem_addr = r_wr_ptr;
        end else if (r_state == StDrain) begin
            o_mem_addr = r_rd_ptr;
        end
    end

endmodule

// File: tb/tb_sort_session_ctrl.sv
// Directed bench for sort_session_ctrl with a behavioural memory and sorter.
module tb_sort_session_ctrl;

    typedef logic [7:0] arr8_t [8];

    logic       clk, rst_n, abort;
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_data, out_data, mem_wdata, mem_rdata;
    logic [2:0] mem_addr;
    logic       mem_we, mem_owner, sort_clr, sort_start, sort_done, busy, err;
    logic       sort_now;
    logic [7:0] swp, hold;

    arr8_t mem, sorted, load_vals, exp_vals;
    int    n_pass, n_checks;

    sort_session_ctrl #(
        .DW      (8),
        .TIMEOUT (16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_abort      (abort),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_last   (out_last),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .i_mem_rdata  (mem_rdata),
        .o_mem_owner  (mem_owner),
        .o_sort_clr   (sort_clr),
        .o_sort_start (sort_start),
        .i_sort_done  (sort_done),
        .o_busy       (busy),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sorter: rewrites memory in ascending order when sort_now is pulsed.
    always_comb begin
        sorted = mem;
        swp    = '0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (sorted[j] > sorted[j+1]) begin
                    swp         = sorted[j];
                    sorted[j]   = sorted[j+1];
                    sorted[j+1] = swp;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mem_we && !mem_owner) mem[mem_addr] <= mem_wdata;
        else if (sort_now) mem <= sorted;
    end

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_n(input int n, input bit gaps);
        int i;
        i = 0;
        while (i < n) begin
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0;
                step();
            end else begin
                in_valid = 1'b1;
                in_data  = load_vals[i];
                #1;
                check("load_ready", {31'd0, in_ready}, 1);
                check("load_we", {31'd0, mem_we}, 1);
                check("load_addr", {29'd0, mem_addr}, i);
                check("load_wdata", {24'd0, mem_wdata}, {24'd0, load_vals[i]});
                step();
                i++;
            end
        end
        in_valid = 1'b0;
        #1;
    endtask

    task automatic to_sort();
        check("clr_pulse", {31'd0, sort_clr}, 1);
        check("clr_owner", {31'd0, mem_owner}, 1);
        check("clr_no_ready", {31'd0, in_ready}, 0);
        step();
        check("start_pulse", {31'd0, sort_start}, 1);
        check("start_clr_low", {31'd0, sort_clr}, 0);
        step();
        check("sort_owner", {31'd0, mem_owner}, 1);
        check("sort_no_we", {31'd0, mem_we}, 0);
        check("sort_start_low", {31'd0, sort_start}, 0);
    endtask

    task automatic finish_sort();
        sort_now = 1'b1;
        step();
        sort_now  = 1'b0;
        sort_done = 1'b1;
        #1;
        step();
        sort_done = 1'b0;
        #1;
    endtask

    task automatic drain(input bit gaps);
        int i;
        int budget;
        i      = 0;
        budget = 0;
        while (i < 8 && budget < 100) begin
            budget++;
            out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("drain_valid", {31'd0, out_valid}, 1);
            check("drain_data", {24'd0, out_data}, {24'd0, exp_vals[i]});
            check("drain_last", {31'd0, out_last}, {31'd0, (i == 7)});
            if (out_ready) begin
                step();
                i++;
            end else begin
                hold = out_data;
                step();
                check("stall_stable", {24'd0, out_data}, {24'd0, hold});
            end
        end
        if (i < 8) check("drain_budget", i, 8);
        out_ready = 1'b0;
        #1;
        check("post_drain_ready", {31'd0, in_ready}, 1);
        check("post_drain_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        n_pass    = 0;
        n_checks  = 0;
        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        sort_done = 1'b0;
        sort_now  = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, err}, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, in_ready}, 1);
        check("rel_busy", {31'd0, busy}, 0);

        // Session 1: back-to-back, sort_done held high during LOAD must be ignored.
        load_vals = '{8'd7, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0};
        exp_vals  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        sort_done = 1'b1;
        load_n(8, 1'b0);
        sort_done = 1'b0;
        #1;
        to_sort();
        repeat (5) step();
        finish_sort();
        drain(1'b0);

        // Session 2: random gaps on both streams.
        load_n(8, 1'b1);
        to_sort();
        finish_sort();
        drain(1'b1);

        // Timeout then abort out of ERR.
        load_n(8, 1'b0);
        to_sort();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) check("pre_timeout_err", {31'd0, err}, 0);
            if (k == 16) check("timeout_err", {31'd0, err}, 1);
        end
        check("err_in_ready", {31'd0, in_ready}, 0);
        check("err_out_valid", {31'd0, out_valid}, 0);
        abort = 1'b1;
        #1;
        check("abort_clr", {31'd0, sort_clr}, 1);
        step();
        abort = 1'b0;
        #1;
        check("abort_err_clr", {31'd0, err}, 0);
        check("abort_idle", {31'd0, busy}, 0);

        // Abort after 4 beats, then a fresh session must hold only the new values.
        load_vals = '{8'd99, 8'd98, 8'd97, 8'd96, 8'd0, 8'd0, 8'd0, 8'd0};
        load_n(4, 1'b0);
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        check("abort_load_ready", {31'd0, in_ready}, 0);
        check("abort_load_we", {31'd0, mem_we}, 0);
        check("abort_load_clr", {31'd0, sort_clr}, 1);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_load_idle", {31'd0, busy}, 0);
        load_vals = '{8'd40, 8'd10, 8'd70, 8'd20, 8'd80, 8'd30, 8'd60, 8'd50};
        exp_vals  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        load_n(8, 1'b0);
        to_sort();
        finish_sort();
        drain(1'b0);

        // done coinciding with the last timer cycle wins over timeout.
        load_n(8, 1'b0);
        to_sort();
        sort_now = 1'b1;
        step();
        sort_now = 1'b0;
        repeat (14) step();
        sort_done = 1'b1;
        #1;
        check("coinc_err_low", {31'd0, err}, 0);
        step();
        sort_done = 1'b0;
        #1;
        check("coinc_drain", {31'd0, out_valid}, 1);
        check("coinc_no_err", {31'd0, err}, 0);
        drain(1'b0);

        // Reset mid-SORT.
        load_n(8, 1'b0);
        to_sort();
        rst_n = 1'b0;
        #1;
        check("rsort_owner", {31'd0, mem_owner}, 0);
        check("rsort_busy", {31'd0, busy}, 0);
        check("rsort_ready", {31'd0, in_ready}, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rsort_rel_ready", {31'd0, in_ready}, 1);
        check("rsort_rel_busy", {31'd0, busy}, 0);

        // Reset mid-DRAIN: out_data must drop even though memory holds 10 at address 0.
        load_n(8, 1'b0);
        to_sort();
        finish_sort();
        check("rdrain_pre_valid", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("rdrain_valid", {31'd0, out_valid}, 0);
        check("rdrain_data", {24'd0, out_data}, 0);
        check("rdrain_busy", {31'd0, busy}, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rdrain_rel_ready", {31'd0, in_ready}, 1);

        // Abort in IDLE blocks the handshake but does not pulse sort_clr.
        in_valid = 1'b1;
        in_data  = 8'h55;
        abort    = 1'b1;
        #1;
        check("idle_abort_ready", {31'd0, in_ready}, 0);
        check("idle_abort_we", {31'd0, mem_we}, 0);
        check("idle_abort_clr", {31'd0, sort_clr}, 0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("idle_abort_stay", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
